// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the program-counter sequencer.
package pc_seq_pkg;

   // Fetch-side control state: RUN fetches, HALT is terminal until reset.
   typedef enum logic {
      PC_RUN  = 1'b0,
      PC_HALT = 1'b1
   } pc_state_t;

   // CPU-wide defaults for the PC datapath.
   localparam int PC_WIDTH_DEF  = 16;
   localparam int INC_DEF       = 2;
   localparam int RESET_VEC_DEF = 0;

endpackage : pc_seq_pkg

// File: rtl/pc_seq_if.sv
// Fetch-stage control/status bundle between the PC sequencer and its users.
interface pc_seq_if #(
   parameter int PC_WIDTH = pc_seq_pkg::PC_WIDTH_DEF
);
   logic                freeze_n;
   logic                redirect_valid;
   logic [PC_WIDTH-1:0] redirect_target;
   logic                halt_req;
   logic [PC_WIDTH-1:0] pc_out;
   logic [PC_WIDTH-1:0] pc_plus_out;
   logic                fetch_valid;
   logic                halted;
   logic                redirect_pending;

   // Pipeline side: drives stall/redirect/halt, observes the PC.
   modport master (
      output freeze_n, redirect_valid, redirect_target, halt_req,
      input  pc_out, pc_plus_out, fetch_valid, halted, redirect_pending
   );

   // Sequencer side.
   modport slave (
      input  freeze_n, redirect_valid, redirect_target, halt_req,
      output pc_out, pc_plus_out, fetch_valid, halted, redirect_pending
   );
endinterface : pc_seq_if

// File: rtl/pc_seq_dff_reg_n.sv
// N-bit register with write enable and asynchronous active-high reset to RST_VAL.
module pc_seq_dff_reg_n #(
   parameter int           N       = 16,
   parameter logic [N-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wen,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   // Load d when enabled; reset is immediate, independent of the clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RST_VAL;
      end else if (wen) begin
         q <= d;
      end
   end

endmodule : pc_seq_dff_reg_n

// File: rtl/pc_seq.sv
// Program-counter sequencer: next-PC priority mux, one-entry redirect buffer
// for redirects that arrive during a freeze, and a RUN/HALT state flop.
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter int                  PC_WIDTH  = PC_WIDTH_DEF,
   parameter int                  INC       = INC_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_VEC = PC_WIDTH'(RESET_VEC_DEF)
) (
   input  logic     clk,
   input  logic     rst,
   pc_seq_if.slave  bus
);

   localparam logic [PC_WIDTH-1:0] INC_V = PC_WIDTH'(INC);

   pc_state_t           state_reg;
   logic                pending_reg;
   logic                halted_reg;
   logic [PC_WIDTH-1:0] pc_reg;
   logic [PC_WIDTH-1:0] pend_target_reg;
   logic [PC_WIDTH-1:0] pc_plus;
   logic [PC_WIDTH-1:0] pc_next;
   logic                pc_wen;
   logic                pend_wen;
   logic                run;

   assign run     = (state_reg == PC_RUN);
   // Truncating add: the top of the address space wraps to low addresses.
   assign pc_plus = pc_reg + INC_V;

   // Next-PC priority: live redirect, then buffered redirect, then increment.
   // A halt request with no redirect leaves the PC unwritten so it holds.
   always_comb begin
      pc_next = pc_plus;
      pc_wen  = 1'b0;
      if (run && bus.freeze_n) begin
         if (bus.redirect_valid) begin
            pc_next = bus.redirect_target;
            pc_wen  = 1'b1;
         end else if (pending_reg) begin
            pc_next = pend_target_reg;
            pc_wen  = 1'b1;
         end else if (!bus.halt_req) begin
            pc_next = pc_plus;
            pc_wen  = 1'b1;
         end
      end
   end

   // Redirects seen during a stall are buffered; the youngest one wins.
   assign pend_wen = run && !bus.freeze_n && bus.redirect_valid;

   pc_seq_dff_reg_n #(
      .N       (PC_WIDTH),
      .RST_VAL (RESET_VEC)
   ) u_pc_reg (
      .clk (clk),
      .rst (rst),
      .wen (pc_wen),
      .d   (pc_next),
      .q   (pc_reg)
   );

   pc_seq_dff_reg_n #(
      .N       (PC_WIDTH),
      .RST_VAL ('0)
   ) u_pend_reg (
      .clk (clk),
      .rst (rst),
      .wen (pend_wen),
      .d   (bus.redirect_target),
      .q   (pend_target_reg)
   );

   // RUN/HALT control with buffered-redirect flag; any redirect (live or
   // buffered) flushes a simultaneous halt request, and HALT only exits on rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= PC_RUN;
         pending_reg <= 1'b0;
         halted_reg  <= 1'b0;
      end else begin
         case (state_reg)
            PC_RUN: begin
               if (!bus.freeze_n) begin
                  if (bus.redirect_valid) begin
                     pending_reg <= 1'b1;
                  end
               end else if (bus.redirect_valid || pending_reg) begin
                  pending_reg <= 1'b0;
               end else if (bus.halt_req) begin
                  state_reg  <= PC_HALT;
                  halted_reg <= 1'b1;
               end
            end
            PC_HALT: begin
               state_reg  <= PC_HALT;
               halted_reg <= 1'b1;
            end
            default: begin
               state_reg <= PC_RUN;
            end
         endcase
      end
   end

   assign bus.pc_out           = pc_reg;
   assign bus.pc_plus_out      = pc_plus;
   assign bus.fetch_valid      = run && bus.freeze_n;
   assign bus.halted           = halted_reg;
   assign bus.redirect_pending = pending_reg;

endmodule : pc_seq

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq with hand-computed expectations (16-bit PC, INC=2, reset vector 0).
`timescale 1ns/1ps
module tb_pc_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   check_cnt = 0;
   int   error_cnt = 0;

   pc_seq_if #(.PC_WIDTH(16)) bus ();

   pc_seq #(
      .PC_WIDTH  (16),
      .INC       (2),
      .RESET_VEC (16'h0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Compare one observed value with its expectation and count it.
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs !== exp) begin
         error_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, obs);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fz, input logic rv, input logic [15:0] rt, input logic hr);
      bus.freeze_n        = fz;
      bus.redirect_valid  = rv;
      bus.redirect_target = rt;
      bus.halt_req        = hr;
   endtask

   logic [15:0] exp_seq [5] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008};

   initial begin
      drive(1'b0, 1'b0, 16'h0000, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // 1: reset state and sequential increment
      check_val("rst_pc", 32'(bus.pc_out), 32'h0000);
      check_val("rst_halted", 32'(bus.halted), 32'h0);
      check_val("rst_pending", 32'(bus.redirect_pending), 32'h0);
      drive(1'b1, 1'b0, 16'h0000, 1'b0);
      #1;
      check_val("run_fetch_valid", 32'(bus.fetch_valid), 32'h1);
      check_val("run_pc_plus", 32'(bus.pc_plus_out), 32'h0002);
      for (int i = 1; i < 5; i++) begin
         step();
         check_val($sformatf("seq_pc%0d", i), 32'(bus.pc_out), 32'(exp_seq[i]));
      end

      // 2: two redirects during a freeze, youngest wins at release
      drive(1'b0, 1'b1, 16'h0100, 1'b0);
      step();
      check_val("frz1_pending", 32'(bus.redirect_pending), 32'h1);
      check_val("frz1_pc_hold", 32'(bus.pc_out), 32'h0008);
      drive(1'b0, 1'b1, 16'h0200, 1'b0);
      step();
      check_val("frz2_pc_hold", 32'(bus.pc_out), 32'h0008);
      check_val("frz_fetch_valid", 32'(bus.fetch_valid), 32'h0);
      drive(1'b1, 1'b0, 16'h0000, 1'b0);
      step();
      check_val("release_pc", 32'(bus.pc_out), 32'h0200);
      check_val("release_pending", 32'(bus.redirect_pending), 32'h0);

      // 3: wrap at the top of the address space
      drive(1'b1, 1'b1, 16'hFFFE, 1'b0);
      step();
      check_val("top_pc", 32'(bus.pc_out), 32'hFFFE);
      check_val("top_pc_plus", 32'(bus.pc_plus_out), 32'h0000);
      drive(1'b1, 1'b0, 16'h0000, 1'b0);
      step();
      check_val("wrap_pc", 32'(bus.pc_out), 32'h0000);
      check_val("wrap_pc_plus", 32'(bus.pc_plus_out), 32'h0002);

      // 4: redirect suppresses a simultaneous halt, then halt alone
      drive(1'b1, 1'b1, 16'h0040, 1'b1);
      step();
      check_val("rdhalt_pc", 32'(bus.pc_out), 32'h0040);
      check_val("rdhalt_halted", 32'(bus.halted), 32'h0);
      drive(1'b1, 1'b0, 16'h0000, 1'b1);
      step();
      check_val("halt_halted", 32'(bus.halted), 32'h1);
      check_val("halt_pc", 32'(bus.pc_out), 32'h0040);
      check_val("halt_fetch_valid", 32'(bus.fetch_valid), 32'h0);

      // 5: HALT ignores inputs; asynchronous reset exits it between edges
      drive(1'b0, 1'b1, 16'h1234, 1'b0);
      step();
      drive(1'b1, 1'b1, 16'h5678, 1'b0);
      step();
      check_val("inhalt_pc", 32'(bus.pc_out), 32'h0040);
      check_val("inhalt_halted", 32'(bus.halted), 32'h1);
      check_val("inhalt_pending", 32'(bus.redirect_pending), 32'h0);
      drive(1'b0, 1'b0, 16'h0000, 1'b0);
      #2 rst = 1'b1;
      #1;
      check_val("async_rst_pc", 32'(bus.pc_out), 32'h0000);
      check_val("async_rst_halted", 32'(bus.halted), 32'h0);
      #1 rst = 1'b0;
      step();

      // 6: live redirect beats the buffered one at freeze release
      drive(1'b0, 1'b1, 16'h0500, 1'b0);
      step();
      check_val("buf_pending", 32'(bus.redirect_pending), 32'h1);
      drive(1'b1, 1'b1, 16'h0300, 1'b0);
      step();
      check_val("live_pc", 32'(bus.pc_out), 32'h0300);
      check_val("live_pending", 32'(bus.redirect_pending), 32'h0);
      drive(1'b1, 1'b0, 16'h0000, 1'b0);
      step();
      check_val("after_live_pc", 32'(bus.pc_out), 32'h0302);

      // halt_req ignored while frozen
      drive(1'b0, 1'b0, 16'h0000, 1'b1);
      step();
      check_val("frz_halt_halted", 32'(bus.halted), 32'h0);
      check_val("frz_halt_pc", 32'(bus.pc_out), 32'h0302);

      // buffered redirect also suppresses a halt at release
      drive(1'b0, 1'b1, 16'h0600, 1'b0);
      step();
      drive(1'b1, 1'b0, 16'h0000, 1'b1);
      step();
      check_val("bufhalt_pc", 32'(bus.pc_out), 32'h0600);
      check_val("bufhalt_halted", 32'(bus.halted), 32'h0);
      step();
      check_val("bufhalt_then_halted", 32'(bus.halted), 32'h1);
      check_val("bufhalt_then_pc", 32'(bus.pc_out), 32'h0600);

      $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
      $finish;
   end

endmodule : tb_pc_seq
